// File: rtl/legv8_pkg.sv
// legv8_pkg: opcode prefixes, ALUOp encodings, immediate formats and the control bundle shared by the decoder
package legv8_pkg;

    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [8:0]  OP_MOVZ = 9'b110100101;
    localparam logic [8:0]  OP_MOVK = 9'b111100101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [5:0]  OP_BL   = 6'b100101;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_PASS = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] ALUOP_MOVE = 2'b11;

    // Immediate layouts; FMT_NONE yields zero (R-type and unrecognised opcodes)
    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_B,
        FMT_CB,
        FMT_D,
        FMT_I,
        FMT_IW
    } imm_fmt_e;

    typedef struct packed {
        logic       reg2loc;
        logic       uncondbranch;
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/legv8_decoder_if.sv
// legv8_decoder_if: instruction in, register indices, immediate and datapath controls out
interface legv8_decoder_if;

    logic [31:0] instruction;
    logic [4:0]  register1;
    logic [4:0]  register2;
    logic [4:0]  writeRegister;
    logic [31:0] immediate;
    logic        Reg2Loc;
    logic        Uncondbranch;
    logic        Branch;
    logic        MemRead;
    logic        MemtoReg;
    logic        MemWrite;
    logic        ALUSrc;
    logic        RegWrite;
    logic [1:0]  ALUOp;
    logic        illegal;

    modport master (
        output instruction,
        input  register1, register2, writeRegister, immediate,
        input  Reg2Loc, Uncondbranch, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp, illegal
    );

    modport slave (
        input  instruction,
        output register1, register2, writeRegister, immediate,
        output Reg2Loc, Uncondbranch, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp, illegal
    );

endinterface

// File: rtl/legv8_imm_gen.sv
// legv8_imm_gen: builds the unshifted 32-bit immediate for the selected instruction format
module legv8_imm_gen
    import legv8_pkg::*;
(
    input  logic [25:0] instr_i,
    input  imm_fmt_e    fmt_i,
    output logic [31:0] imm_o
);

    // Branch offsets stay in word units; MOVZ/MOVK ignore the hw shift field
    always_comb begin
        imm_o = fmt_i == FMT_B  ? {{6{instr_i[25]}}, instr_i[25:0]}  :
                fmt_i == FMT_CB ? {{13{instr_i[23]}}, instr_i[23:5]} :
                fmt_i == FMT_D  ? {{23{instr_i[20]}}, instr_i[20:12]} :
                fmt_i == FMT_I  ? {{20{instr_i[21]}}, instr_i[21:10]} :
                fmt_i == FMT_IW ? {16'd0, instr_i[20:5]}             :
                                  32'd0;
    end

endmodule

// File: rtl/legv8_decoder.sv
// legv8_decoder: registered LEGv8 decode of register indices, immediate and single-cycle datapath controls
module legv8_decoder
    import legv8_pkg::*;
#(
    parameter logic [4:0] LINK_REG = 5'd30
) (
    input  logic            clk,
    input  logic            reset,
    legv8_decoder_if.slave  bus
);

    logic [31:0] ins;
    ctrl_t       ctrl_d, ctrl_q;
    imm_fmt_e    fmt;
    logic        illegal_d, illegal_q;
    logic        link;
    logic [31:0] imm_d, imm_q;
    logic [4:0]  reg1_d, reg1_q;
    logic [4:0]  reg2_d, reg2_q;
    logic [4:0]  wreg_d, wreg_q;

    assign ins = bus.instruction;

    legv8_imm_gen u_imm_gen (
        .instr_i (ins[25:0]),
        .fmt_i   (fmt),
        .imm_o   (imm_d)
    );

    // Opcode classification, longest prefix checked first
    always_comb begin
        ctrl_d    = '0;
        fmt       = FMT_NONE;
        illegal_d = 1'b0;
        link      = 1'b0;
        if (ins[31:21] inside {OP_AND, OP_ADD, OP_ORR, OP_SUB}) begin
            ctrl_d.regwrite = 1'b1;
            ctrl_d.aluop    = ALUOP_FUNC;
        end else if (ins[31:21] == OP_STUR) begin
            ctrl_d.reg2loc  = 1'b1;
            ctrl_d.alusrc   = 1'b1;
            ctrl_d.memwrite = 1'b1;
            ctrl_d.aluop    = ALUOP_ADD;
            fmt             = FMT_D;
        end else if (ins[31:21] == OP_LDUR) begin
            ctrl_d.alusrc   = 1'b1;
            ctrl_d.memread  = 1'b1;
            ctrl_d.memtoreg = 1'b1;
            ctrl_d.regwrite = 1'b1;
            ctrl_d.aluop    = ALUOP_ADD;
            fmt             = FMT_D;
        end else if (ins[31:22] == OP_ADDI || ins[31:22] == OP_SUBI) begin
            ctrl_d.alusrc   = 1'b1;
            ctrl_d.regwrite = 1'b1;
            ctrl_d.aluop    = ALUOP_FUNC;
            fmt             = FMT_I;
        end else if (ins[31:23] == OP_MOVZ || ins[31:23] == OP_MOVK) begin
            ctrl_d.alusrc   = 1'b1;
            ctrl_d.regwrite = 1'b1;
            ctrl_d.aluop    = ALUOP_MOVE;
            fmt             = FMT_IW;
        end else if (ins[31:24] == OP_CBZ || ins[31:24] == OP_CBNZ) begin
            ctrl_d.reg2loc  = 1'b1;
            ctrl_d.branch   = 1'b1;
            ctrl_d.aluop    = ALUOP_PASS;
            fmt             = FMT_CB;
        end else if (ins[31:26] == OP_B) begin
            ctrl_d.uncondbranch = 1'b1;
            ctrl_d.aluop        = ALUOP_PASS;
            fmt                 = FMT_B;
        end else if (ins[31:26] == OP_BL) begin
            ctrl_d.uncondbranch = 1'b1;
            ctrl_d.regwrite     = 1'b1;
            ctrl_d.aluop        = ALUOP_PASS;
            fmt                 = FMT_B;
            link                = 1'b1;
        end else begin
            illegal_d = 1'b1;
        end
    end

    // Register fields decode for every opcode, including unrecognised ones
    always_comb begin
        reg1_d = ins[9:5];
        reg2_d = ctrl_d.reg2loc ? ins[4:0] : ins[20:16];
        wreg_d = link ? LINK_REG : ins[4:0];
    end

    // Output registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            imm_q     <= '0;
            reg1_q    <= '0;
            reg2_q    <= '0;
            wreg_q    <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            imm_q     <= imm_d;
            reg1_q    <= reg1_d;
            reg2_q    <= reg2_d;
            wreg_q    <= wreg_d;
        end
    end

    assign bus.register1     = reg1_q;
    assign bus.register2     = reg2_q;
    assign bus.writeRegister = wreg_q;
    assign bus.immediate     = imm_q;
    assign bus.Reg2Loc       = ctrl_q.reg2loc;
    assign bus.Uncondbranch  = ctrl_q.uncondbranch;
    assign bus.Branch        = ctrl_q.branch;
    assign bus.MemRead       = ctrl_q.memread;
    assign bus.MemtoReg      = ctrl_q.memtoreg;
    assign bus.MemWrite      = ctrl_q.memwrite;
    assign bus.ALUSrc        = ctrl_q.alusrc;
    assign bus.RegWrite      = ctrl_q.regwrite;
    assign bus.ALUOp         = ctrl_q.aluop;
    assign bus.illegal       = illegal_q;

endmodule

// File: tb/tb_legv8_decoder.sv
// tb_legv8_decoder: directed decode vectors with hand-computed results for legv8_decoder
module tb_legv8_decoder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    legv8_decoder_if bus ();

    legv8_decoder #(.LINK_REG(5'd30)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {register1, register2, writeRegister, immediate,
    //  Reg2Loc, Uncondbranch, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp, illegal}
    function automatic logic [57:0] obs();
        return {bus.register1, bus.register2, bus.writeRegister, bus.immediate,
                bus.Reg2Loc, bus.Uncondbranch, bus.Branch, bus.MemRead, bus.MemtoReg,
                bus.MemWrite, bus.ALUSrc, bus.RegWrite, bus.ALUOp, bus.illegal};
    endfunction

    task automatic drive(input logic [31:0] ins);
        @(negedge clk);
        bus.instruction = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [57:0] exp;
        bus.instruction = 32'h8A040041;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (obs() !== 58'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected %h", obs(), 58'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp = {5'd2, 5'd4, 5'd1, 32'd0, 11'b00000001100};
        n_tests++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL and_decode: got %h expected %h", obs(), exp);
        end
    endtask

    task automatic test_branch();
        logic [57:0] exp;
        drive(32'h17FFFFFF);
        exp = {5'd31, 5'd31, 5'd31, 32'hFFFFFFFF, 11'b01000000010};
        n_tests++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL b_decode: got %h expected %h", obs(), exp);
        end
        drive(32'h94202002);
        exp = {5'd0, 5'd0, 5'd30, 32'd2105346, 11'b01000001010};
        n_tests++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL bl_decode: got %h expected %h", obs(), exp);
        end
    endtask

    task automatic test_cond_branch();
        logic [57:0] exp;
        drive(32'hB42D3945);
        exp = {5'd10, 5'd5, 5'd5, 32'd92618, 11'b10100000010};
        n_tests++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL cbz_decode: got %h expected %h", obs(), exp);
        end
        drive(32'hB5D2C6C3);
        exp = {5'd22, 5'd3, 5'd3, 32'hFFFE9636, 11'b10100000010};
        n_tests++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL cbnz_decode: got %h expected %h", obs(), exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [4];
        logic [57:0] exp [4];
        ins[0] = 32'hF81B8044;
        exp[0] = {5'd2, 5'd4, 5'd4, 32'hFFFFFFB8, 11'b10000110000};
        ins[1] = 32'hF8462060;
        exp[1] = {5'd3, 5'd6, 5'd0, 32'd98, 11'b00011011000};
        ins[2] = 32'h913E03E0;
        exp[2] = {5'd31, 5'd30, 5'd0, 32'hFFFFFF80, 11'b00000011100};
        ins[3] = 32'hF28000E2;
        exp[3] = {5'd7, 5'd0, 5'd2, 32'd7, 11'b00000011110};
        for (int i = 0; i < 4; i++) begin
            drive(ins[i]);
            n_tests++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b_%0d: got %h expected %h", i, obs(), exp[i]);
            end
        end
    endtask

    task automatic test_illegal_async_reset();
        logic [57:0] exp;
        drive(32'h00000000);
        exp = {5'd0, 5'd0, 5'd0, 32'd0, 11'b00000000001};
        n_tests++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL illegal_decode: got %h expected %h", obs(), exp);
        end
        bus.instruction = 32'h8A040041;
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (obs() !== 58'd0) begin
            n_fail++;
            $display("FAIL async_reset_clear: got %h expected %h", obs(), 58'd0);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (obs() !== 58'd0) begin
            n_fail++;
            $display("FAIL reset_held_edge: got %h expected %h", obs(), 58'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++;
        if (obs() !== 58'd0) begin
            n_fail++;
            $display("FAIL release_no_edge: got %h expected %h", obs(), 58'd0);
        end
        @(posedge clk);
        #1;
        exp = {5'd2, 5'd4, 5'd1, 32'd0, 11'b00000001100};
        n_tests++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL first_after_release: got %h expected %h", obs(), exp);
        end
    endtask

    initial begin
        bus.instruction = 32'h0;
        test_reset();
        test_branch();
        test_cond_branch();
        test_back_to_back();
        test_illegal_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
